// File: rtl/frac_pkg.sv
// Shared definitions for the fractal scan controller, its engine and the bench.
package frac_pkg;

  localparam int FRAC_W  = 28;
  localparam int INT_W   = 4;
  localparam int COORD_W = INT_W + FRAC_W;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_NEXT  = 3'd4
  } scan_state_t;

endpackage

// File: rtl/frac_scan_ctrl_if.sv
// Engine job handshake plus pixel-buffer write port of the scan controller.
interface frac_scan_ctrl_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 19
);

  logic signed [N-1:0] frac_cx;
  logic signed [N-1:0] frac_cy;
  logic [15:0]         frac_max_iter;
  logic                frac_go;
  logic                frac_busy;
  logic                frac_done_tick;
  logic                frac_found;
  logic                pix_we;
  logic [ADDR_W-1:0]   pix_addr;
  logic                pix_data;

  // Scan controller side
  modport master (
    output frac_cx, frac_cy, frac_max_iter, frac_go,
    input  frac_busy, frac_done_tick, frac_found,
    output pix_we, pix_addr, pix_data
  );

  // Engine and frame-buffer side
  modport slave (
    input  frac_cx, frac_cy, frac_max_iter, frac_go,
    output frac_busy, frac_done_tick, frac_found,
    input  pix_we, pix_addr, pix_data
  );

endinterface

// File: rtl/frac_coord_gen.sv
// Raster position bookkeeping: col/row counters, cx/cy accumulators and
// an incrementing pixel address (no multiplier needed for row*H_RES+col).
module frac_coord_gen #(
  parameter int N      = 32,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                advance,
  input  logic signed [N-1:0] x0,
  input  logic signed [N-1:0] y0,
  input  logic signed [N-1:0] step,
  output logic signed [N-1:0] cx,
  output logic signed [N-1:0] cy,
  output logic [ADDR_W-1:0]   addr,
  output logic                last_col,
  output logic                last_pix
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(V_RES - 1);

  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic signed [N-1:0] x0_q;
  logic signed [N-1:0] step_q;

  assign last_col = (col == LAST_COL);
  assign last_pix = last_col && (row == LAST_ROW);

  // Load the frame origin, then step right along a row or wrap to the next row (y decreases downward)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q   <= '0;
      step_q <= '0;
      cx     <= '0;
      cy     <= '0;
      col    <= '0;
      row    <= '0;
      addr   <= '0;
    end else if (load) begin
      x0_q   <= x0;
      step_q <= step;
      cx     <= x0;
      cy     <= y0;
      col    <= '0;
      row    <= '0;
      addr   <= '0;
    end else if (advance) begin
      addr <= addr + ADDR_W'(1);
      if (last_col) begin
        col <= '0;
        row <= row + ROW_W'(1);
        cx  <= x0_q;
        cy  <= cy - step_q;
      end else begin
        col <= col + COL_W'(1);
        cx  <= cx + step_q;
      end
    end
  end

endmodule

// File: rtl/frac_scan_ctrl.sv
// Frame sequencer: issues one engine job per pixel in raster order and
// writes each found bit to the pixel buffer.
module frac_scan_ctrl
  import frac_pkg::*;
#(
  parameter int N      = 32,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic                frac_clk,
  input  logic                frac_rst_n,
  input  logic                scan_start,
  input  logic                scan_abort,
  input  logic signed [N-1:0] x0,
  input  logic signed [N-1:0] y0,
  input  logic signed [N-1:0] step,
  input  logic [15:0]         max_iter,
  frac_scan_ctrl_if.master    bus,
  output logic                scan_busy,
  output logic                scan_done_tick
);

  scan_state_t         state;
  logic                go_q;
  logic                we_q;
  logic                data_q;
  logic [15:0]         iter_q;
  logic                load;
  logic                advance;
  logic                last_col;
  logic                last_pix;
  logic signed [N-1:0] cx;
  logic signed [N-1:0] cy;
  logic [ADDR_W-1:0]   addr;

  assign load    = (state == S_IDLE) && scan_start;
  assign advance = (state == S_NEXT) && !last_pix && !scan_abort;

  frac_coord_gen #(
    .N      (N),
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_coord (
    .clk      (frac_clk),
    .rst_n    (frac_rst_n),
    .load     (load),
    .advance  (advance),
    .x0       (x0),
    .y0       (y0),
    .step     (step),
    .cx       (cx),
    .cy       (cy),
    .addr     (addr),
    .last_col (last_col),
    .last_pix (last_pix)
  );

  assign bus.frac_cx       = cx;
  assign bus.frac_cy       = cy;
  assign bus.frac_max_iter = iter_q;
  assign bus.frac_go       = go_q;
  assign bus.pix_we        = we_q;
  assign bus.pix_addr      = addr;
  assign bus.pix_data      = data_q;

  // Scan FSM; outputs are registered on the edge entering the state that shows them,
  // so frac_go is visible in the first ISSUE cycle whenever the engine was idle
  always_ff @(posedge frac_clk or negedge frac_rst_n) begin
    if (!frac_rst_n) begin
      state          <= S_IDLE;
      go_q           <= 1'b0;
      we_q           <= 1'b0;
      data_q         <= 1'b0;
      iter_q         <= '0;
      scan_busy      <= 1'b0;
      scan_done_tick <= 1'b0;
    end else begin
      go_q           <= 1'b0;
      we_q           <= 1'b0;
      scan_done_tick <= 1'b0;
      if (state != S_IDLE && scan_abort) begin
        state     <= S_IDLE;
        scan_busy <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (scan_start) begin
              iter_q    <= max_iter;
              scan_busy <= 1'b1;
              go_q      <= !bus.frac_busy;
              state     <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (go_q) state <= S_WAIT;
            else      go_q  <= !bus.frac_busy;
          end
          S_WAIT: begin
            if (bus.frac_done_tick) begin
              data_q <= bus.frac_found;
              we_q   <= 1'b1;
              state  <= S_WRITE;
            end
          end
          S_WRITE: begin
            state <= S_NEXT;
            if (last_pix) begin
              scan_done_tick <= 1'b1;
              scan_busy      <= 1'b0;
            end
          end
          S_NEXT: begin
            if (last_pix) begin
              state <= S_IDLE;
            end else begin
              go_q  <= !bus.frac_busy;
              state <= S_ISSUE;
            end
          end
          default: begin
            state     <= S_IDLE;
            scan_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frac_scan_ctrl.sv
// Directed bench for frac_scan_ctrl on a 4x3 grid with a delay-programmable engine stub.
module tb_frac_scan_ctrl;
  import frac_pkg::*;

  localparam int N    = 32;
  localparam int H    = 4;
  localparam int V    = 3;
  localparam int AW   = 4;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        scan_start = 1'b0;
  logic        scan_abort = 1'b0;
  coord_t      x0 = '0;
  coord_t      y0 = '0;
  coord_t      step = '0;
  logic [15:0] max_iter = '0;
  logic        scan_busy;
  logic        scan_done_tick;

  logic [11:0] pattern = 12'b1011_0010_1101;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  frac_scan_ctrl_if #(.N(N), .ADDR_W(AW)) bus ();

  frac_scan_ctrl #(.N(N), .H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .frac_clk       (clk),
    .frac_rst_n     (rst_n),
    .scan_start     (scan_start),
    .scan_abort     (scan_abort),
    .x0             (x0),
    .y0             (y0),
    .step           (step),
    .max_iter       (max_iter),
    .bus            (bus),
    .scan_busy      (scan_busy),
    .scan_done_tick (scan_done_tick)
  );

  // Engine stub: busy for stub_delay cycles after frac_go, then one done tick with pattern[addr]
  int   stub_delay = 2;
  logic force_busy = 1'b0;
  logic stub_busy;
  logic stub_done;
  logic stub_found;
  int   stub_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_busy  <= 1'b0;
      stub_done  <= 1'b0;
      stub_found <= 1'b0;
      stub_cnt   <= 0;
    end else begin
      stub_done <= 1'b0;
      if (bus.frac_go) begin
        stub_busy  <= 1'b1;
        stub_cnt   <= stub_delay;
        stub_found <= (int'(bus.pix_addr) < NPIX) ? pattern[bus.pix_addr] : 1'b0;
      end else if (stub_busy) begin
        if (stub_cnt <= 1) begin
          stub_busy <= 1'b0;
          stub_done <= 1'b1;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  assign bus.frac_busy      = stub_busy | force_busy;
  assign bus.frac_done_tick = stub_done;
  assign bus.frac_found     = stub_found;

  // Event log sampled on the falling edge
  int      cyc = 0;
  int      go_n = 0;
  int      we_n = 0;
  int      dn = 0;
  int      done_n = 0;
  int      sd_cyc = 0;
  int      stab_err = 0;
  int      start_cyc = 0;
  bit      start_seen = 1'b0;
  bit      in_job = 1'b0;
  coord_t  job_cx;
  coord_t  job_cy;
  coord_t  go_cx [64];
  coord_t  go_cy [64];
  int      go_cyc [64];
  int      we_cyc [64];
  int      dt_cyc [64];
  logic [AW-1:0] we_addr [64];
  logic    we_data [64];

  always @(negedge clk) begin
    cyc++;
    if (scan_start && !start_seen) begin
      start_cyc  = cyc;
      start_seen = 1'b1;
    end
    if (in_job && (bus.frac_cx !== job_cx || bus.frac_cy !== job_cy)) stab_err++;
    if (bus.frac_done_tick) begin
      if (dn < 64) dt_cyc[dn] = cyc;
      dn++;
      in_job = 1'b0;
    end
    if (bus.frac_go) begin
      if (go_n < 64) begin
        go_cx[go_n]  = bus.frac_cx;
        go_cy[go_n]  = bus.frac_cy;
        go_cyc[go_n] = cyc;
      end
      go_n++;
      job_cx = bus.frac_cx;
      job_cy = bus.frac_cy;
      in_job = 1'b1;
    end
    if (bus.pix_we) begin
      if (we_n < 64) begin
        we_addr[we_n] = bus.pix_addr;
        we_data[we_n] = bus.pix_data;
        we_cyc[we_n]  = cyc;
      end
      we_n++;
    end
    if (scan_done_tick) begin
      sd_cyc = cyc;
      done_n++;
    end
  end

  task automatic clear_log();
    go_n = 0; we_n = 0; dn = 0; done_n = 0; sd_cyc = 0;
    stab_err = 0; start_seen = 1'b0; in_job = 1'b0;
  endtask

  task automatic applyStimulus(input coord_t ax0, input coord_t ay0, input coord_t astep,
                               input logic [15:0] aiter);
    @(posedge clk); #1;
    x0 = ax0; y0 = ay0; step = astep; max_iter = aiter;
    scan_start = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
  endtask

  task automatic wait_frame_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (scan_done_tick) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.frac_cx !== '0 || bus.frac_cy !== '0 || bus.frac_max_iter !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_coords: cx=%h cy=%h iter=%h required 0", bus.frac_cx, bus.frac_cy, bus.frac_max_iter);
    end
    n_checks++;
    if (bus.pix_addr !== '0 || bus.pix_we !== 1'b0 || bus.pix_data !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_pix: addr=%h we=%b data=%b required 0", bus.pix_addr, bus.pix_we, bus.pix_data);
    end
    n_checks++;
    if (bus.frac_go !== 1'b0 || scan_busy !== 1'b0 || scan_done_tick !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: go=%b busy=%b done=%b required 0", bus.frac_go, scan_busy, scan_done_tick);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (scan_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle_busy: got %b required 0", scan_busy);
    end
  endtask

  task automatic test_basic_frame();
    bit ok;
    stub_delay = 2;
    clear_log();
    applyStimulus(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 16'd30);
    wait_frame_done(2000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("[TB] FAIL basic_timeout: done tick not seen, required within 2000 cycles"); end
    n_checks++;
    if (go_n !== 12) begin n_fail++; $display("[TB] FAIL basic_go_count: got %0d required 12", go_n); end
    n_checks++;
    if (go_cx[5] !== 32'hE800_0000 || go_cy[5] !== 32'h0800_0000) begin
      n_fail++;
      $display("[TB] FAIL basic_pix5_coord: got cx=%h cy=%h required cx=e8000000 cy=08000000", go_cx[5], go_cy[5]);
    end
    n_checks++;
    if (go_cx[4] !== 32'hE000_0000 || go_cy[11] !== 32'h0000_0000) begin
      n_fail++;
      $display("[TB] FAIL basic_row_wrap: got cx4=%h cy11=%h required e0000000 00000000", go_cx[4], go_cy[11]);
    end
    n_checks++;
    if (we_n !== 12) begin n_fail++; $display("[TB] FAIL basic_we_count: got %0d required 12", we_n); end
    for (int k = 0; k < NPIX; k++) begin
      n_checks++;
      if (we_addr[k] !== AW'(k) || we_data[k] !== pattern[k]) begin
        n_fail++;
        $display("[TB] FAIL basic_write_%0d: got addr=%0d data=%b required addr=%0d data=%b",
                 k, we_addr[k], we_data[k], k, pattern[k]);
      end
    end
    n_checks++;
    if (done_n !== 1 || sd_cyc !== we_cyc[11] + 1) begin
      n_fail++;
      $display("[TB] FAIL basic_done_tick: got count=%0d cyc=%0d required count=1 cyc=%0d", done_n, sd_cyc, we_cyc[11] + 1);
    end
    n_checks++;
    if (bus.frac_max_iter !== 16'd30 || scan_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_after: got iter=%0d busy=%b required iter=30 busy=0", bus.frac_max_iter, scan_busy);
    end
  endtask

  task automatic test_latency();
    bit ok;
    int bad;
    stub_delay = 3;
    clear_log();
    applyStimulus(32'h0000_0000, 32'h0000_0000, 32'h0100_0000, 16'd7);
    wait_frame_done(2000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("[TB] FAIL lat_timeout: done tick not seen, required within 2000 cycles"); end
    n_checks++;
    if (go_cyc[0] !== start_cyc + 1) begin
      n_fail++;
      $display("[TB] FAIL lat_first_go: got cyc=%0d required %0d", go_cyc[0], start_cyc + 1);
    end
    bad = 0;
    for (int k = 0; k < NPIX - 1; k++) begin
      n_checks++;
      if (we_cyc[k] !== dt_cyc[k] + 1 || go_cyc[k+1] !== dt_cyc[k] + 3) begin
        n_fail++;
        $display("[TB] FAIL lat_pixel_%0d: got we=%0d go=%0d required we=%0d go=%0d",
                 k, we_cyc[k], go_cyc[k+1], dt_cyc[k] + 1, dt_cyc[k] + 3);
      end
    end
    n_checks++;
    if (stab_err !== 0) begin n_fail++; $display("[TB] FAIL lat_coord_stable: got %0d changes required 0", stab_err); end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    stub_delay = 2;
    clear_log();
    @(posedge clk); #1;
    x0 = 32'h0000_0000; y0 = 32'h0000_0000; step = 32'h0200_0000; max_iter = 16'd40;
    scan_start = 1'b1;
    force_busy = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    repeat (4) @(posedge clk);
    #1 force_busy = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (go_n >= 3) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    x0 = 32'h1111_0000; step = 32'h0300_0000; max_iter = 16'd99;
    scan_start = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    wait_frame_done(2000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("[TB] FAIL busy_timeout: done tick not seen, required within 2000 cycles"); end
    n_checks++;
    if (go_cyc[0] !== start_cyc + 6) begin
      n_fail++;
      $display("[TB] FAIL busy_defer: got go cyc=%0d required %0d", go_cyc[0], start_cyc + 6);
    end
    n_checks++;
    if (go_cx[3] !== 32'h0600_0000 || go_cx[4] !== 32'h0000_0000 || go_cy[8] !== 32'hFC00_0000) begin
      n_fail++;
      $display("[TB] FAIL busy_latched_step: got cx3=%h cx4=%h cy8=%h required 06000000 00000000 fc000000",
               go_cx[3], go_cx[4], go_cy[8]);
    end
    n_checks++;
    if (bus.frac_max_iter !== 16'd40 || go_n !== 12) begin
      n_fail++;
      $display("[TB] FAIL busy_restart_ignored: got iter=%0d go=%0d required iter=40 go=12", bus.frac_max_iter, go_n);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    stub_delay = 1;
    clear_log();
    applyStimulus(32'h7000_0000, 32'h0000_0000, 32'h1000_0000, 16'd5);
    wait_frame_done(2000, ok);
    n_checks++;
    if (!ok || done_n !== 1 || we_n !== 12) begin
      n_fail++;
      $display("[TB] FAIL wrap_complete: got ok=%b done=%0d we=%0d required 1 1 12", ok, done_n, we_n);
    end
    n_checks++;
    if (go_cx[1] !== 32'h8000_0000 || go_cx[3] !== 32'hA000_0000) begin
      n_fail++;
      $display("[TB] FAIL wrap_cx: got cx1=%h cx3=%h required 80000000 a0000000", go_cx[1], go_cx[3]);
    end
    n_checks++;
    if (go_cy[4] !== 32'hF000_0000 || go_cx[4] !== 32'h7000_0000) begin
      n_fail++;
      $display("[TB] FAIL wrap_row1: got cx4=%h cy4=%h required 70000000 f0000000", go_cx[4], go_cy[4]);
    end
  endtask

  task automatic test_abort();
    stub_delay = 6;
    clear_log();
    applyStimulus(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 16'd30);
    for (int i = 0; i < 500; i++) begin
      if (go_n >= 6) break;
      @(posedge clk); #1;
    end
    scan_abort = 1'b1;
    @(posedge clk); #1;
    scan_abort = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (we_n !== 5 || we_addr[4] !== AW'(4)) begin
      n_fail++;
      $display("[TB] FAIL abort_writes: got we=%0d last_addr=%0d required we=5 last_addr=4", we_n, we_addr[4]);
    end
    n_checks++;
    if (done_n !== 0 || go_n !== 6 || scan_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_idle: got done=%0d go=%0d busy=%b required 0 6 0", done_n, go_n, scan_busy);
    end
    scan_start = 1'b1;
    scan_abort = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    scan_abort = 1'b0;
    n_checks++;
    if (scan_busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL abort_start_same_cycle: got busy=%b required 1", scan_busy);
    end
    scan_abort = 1'b1;
    @(posedge clk); #1;
    scan_abort = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (scan_busy !== 1'b0 || done_n !== 0) begin
      n_fail++;
      $display("[TB] FAIL abort_second: got busy=%b done=%0d required 0 0", scan_busy, done_n);
    end
  endtask

  task automatic test_async_reset();
    int go_at_reset;
    stub_delay = 2;
    clear_log();
    applyStimulus(32'hE000_0000, 32'h1000_0000, 32'h0800_0000, 16'd30);
    for (int i = 0; i < 500; i++) begin
      if (go_n >= 4) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    go_at_reset = go_n;
    n_checks++;
    if (bus.frac_cx !== '0 || bus.frac_cy !== '0 || bus.frac_max_iter !== '0 || bus.pix_addr !== '0) begin
      n_fail++;
      $display("[TB] FAIL areset_values: got cx=%h cy=%h iter=%h addr=%h required 0",
               bus.frac_cx, bus.frac_cy, bus.frac_max_iter, bus.pix_addr);
    end
    n_checks++;
    if (scan_busy !== 1'b0 || bus.frac_go !== 1'b0 || bus.pix_we !== 1'b0 || scan_done_tick !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL areset_ctrl: got busy=%b go=%b we=%b done=%b required 0",
               scan_busy, bus.frac_go, bus.pix_we, scan_done_tick);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (scan_busy !== 1'b0 || go_n !== go_at_reset || done_n !== 0) begin
      n_fail++;
      $display("[TB] FAIL areset_stays_idle: got busy=%b go=%0d done=%0d required 0 %0d 0",
               scan_busy, go_n, done_n, go_at_reset);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_latency();
    test_busy_ignore();
    test_wrap();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
